// File: rtl/asi_regbank.sv
`default_nettype none
// ============================================================================
// Module : asi_regbank
// Brief  : Register bank behind the user-side port of the AXI slave
//          interface. It holds ID, scratch, control, a 64-bit cycle counter,
//          sticky W1C event status, an unmapped-access error counter and
//          general RW registers. Read data returns after SLV_WS cycles.
// Rev    : 1.0  initial release
// ============================================================================
module asi_regbank #(
  parameter int                 AXI_DW     = 128,
  parameter int                 AXI_AW     = 40,
  parameter int                 AXI_WSTRBW = AXI_DW / 8,
  parameter int                 SLV_WS     = 2,
  parameter int                 REG_NUM    = 16,
  parameter logic [AXI_AW-1:0]  BASE_ADDR  = '0,
  parameter logic [31:0]        ID_VALUE   = 32'hA51_0001,
  parameter int                 EVT_W      = 8
) (
  input  logic                  usr_clk,
  input  logic                  usr_reset,
  input  logic [AXI_AW-1:0]     m_addr,
  input  logic [AXI_DW-1:0]     m_wdata,
  input  logic [AXI_WSTRBW-1:0] m_wstrb,
  input  logic                  m_we,
  input  logic                  m_re,
  output logic [AXI_DW-1:0]     m_rdata,
  input  logic [EVT_W-1:0]      evt,
  output logic [31:0]           ctrl_o,
  output logic                  irq
);

  localparam int OFF_W  = $clog2(AXI_DW / 8);
  localparam int IDX_W  = $clog2(REG_NUM);
  localparam int TAG_LO = OFF_W + IDX_W;
  localparam int GP_NUM = REG_NUM - 8;

  localparam logic [IDX_W-1:0] IDX_ID      = IDX_W'(0);
  localparam logic [IDX_W-1:0] IDX_SCRATCH = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_CTRL    = IDX_W'(2);
  localparam logic [IDX_W-1:0] IDX_COUNTER = IDX_W'(3);
  localparam logic [IDX_W-1:0] IDX_STATUS  = IDX_W'(4);
  localparam logic [IDX_W-1:0] IDX_ERRCNT  = IDX_W'(5);

  // Architectural state
  logic [AXI_DW-1:0] scratch_q, scratch_d;
  logic [31:0]       ctrl_q,    ctrl_d;
  logic [63:0]       cnt_q,     cnt_d;
  logic [EVT_W-1:0]  status_q,  status_d;
  logic [15:0]       errcnt_q,  errcnt_d;
  logic [AXI_DW-1:0] gp_q [GP_NUM];
  logic [AXI_DW-1:0] gp_d [GP_NUM];
  logic              irq_q,     irq_d;

  // Decode
  logic [IDX_W-1:0]  idx;
  logic              hit;
  logic              wr_hit;
  logic [AXI_DW-1:0] bmask;
  logic [31:0]       ctrl_wr;
  logic              cnt_clr;
  logic [EVT_W-1:0]  status_clr;
  logic [AXI_DW-1:0] rd_mux;

  // Byte-offset bits select nothing inside a register
  logic unused_addr;
  assign unused_addr = ^m_addr[OFF_W-1:0];

  assign idx    = m_addr[OFF_W +: IDX_W];
  assign hit    = (m_addr[AXI_AW-1:TAG_LO] == BASE_ADDR[AXI_AW-1:TAG_LO]);
  assign wr_hit = m_we & hit;

  for (genvar i = 0; i < AXI_WSTRBW; i++) begin : g_bmask
    assign bmask[8*i +: 8] = {8{m_wstrb[i]}};
  end

  function automatic logic [AXI_DW-1:0] merge_bytes(input logic [AXI_DW-1:0] cur,
                                                    input logic [AXI_DW-1:0] wd,
                                                    input logic [AXI_DW-1:0] msk);
    return (cur & ~msk) | (wd & msk);
  endfunction

  // cnt_clr is never stored: a write with bit1 set zeroes the counter on the
  // same edge that commits the write, so COUNTER reads 0 in the next cycle.
  assign ctrl_wr    = (ctrl_q & ~bmask[31:0]) | (m_wdata[31:0] & bmask[31:0]);
  assign cnt_clr    = wr_hit && (idx == IDX_CTRL) && ctrl_wr[1];
  assign status_clr = (wr_hit && (idx == IDX_STATUS)) ? (m_wdata[EVT_W-1:0] & bmask[EVT_W-1:0])
                                                      : '0;

  // Next-state computation for every register
  always_comb begin
    scratch_d = scratch_q;
    ctrl_d    = ctrl_q;
    cnt_d     = cnt_q;
    errcnt_d  = errcnt_q;
    gp_d      = gp_q;

    if (wr_hit && (idx == IDX_SCRATCH)) scratch_d = merge_bytes(scratch_q, m_wdata, bmask);
    if (wr_hit && (idx == IDX_CTRL))    ctrl_d    = {ctrl_wr[31:2], 1'b0, ctrl_wr[0]};

    for (int g = 0; g < GP_NUM; g++) begin
      if (wr_hit && (idx == IDX_W'(g + 8))) gp_d[g] = merge_bytes(gp_q[g], m_wdata, bmask);
    end

    if (cnt_clr)        cnt_d = '0;
    else if (ctrl_q[0]) cnt_d = cnt_q + 64'd1;

    // Set beats clear when both hit the same bit
    status_d = (status_q & ~status_clr) | evt;

    // A simultaneous unmapped read and write count once
    if ((m_we | m_re) && !hit && (errcnt_q != 16'hFFFF)) errcnt_d = errcnt_q + 16'd1;

    irq_d = |(status_q & ctrl_q[8 +: EVT_W]);
  end

  // Register update with synchronous reset
  always_ff @(posedge usr_clk) begin
    if (usr_reset) begin
      scratch_q <= '0;
      ctrl_q    <= '0;
      cnt_q     <= '0;
      status_q  <= '0;
      errcnt_q  <= '0;
      irq_q     <= 1'b0;
      for (int g = 0; g < GP_NUM; g++) gp_q[g] <= '0;
    end else begin
      scratch_q <= scratch_d;
      ctrl_q    <= ctrl_d;
      cnt_q     <= cnt_d;
      status_q  <= status_d;
      errcnt_q  <= errcnt_d;
      irq_q     <= irq_d;
      gp_q      <= gp_d;
    end
  end

  // Read multiplexer over the current (pre-write) register state
  always_comb begin
    rd_mux = '0;
    if (hit) begin
      case (idx)
        IDX_ID:      rd_mux[31:0]      = ID_VALUE;
        IDX_SCRATCH: rd_mux            = scratch_q;
        IDX_CTRL:    rd_mux[31:0]      = ctrl_q;
        IDX_COUNTER: rd_mux[63:0]      = cnt_q;
        IDX_STATUS:  rd_mux[EVT_W-1:0] = status_q;
        IDX_ERRCNT:  rd_mux[15:0]      = errcnt_q;
        default:     ;
      endcase
      for (int g = 0; g < GP_NUM; g++) begin
        if (idx == IDX_W'(g + 8)) rd_mux = gp_q[g];
      end
    end
  end

  if (SLV_WS == 0) begin : g_rd_comb
    assign m_rdata = rd_mux;
  end else begin : g_rd_pipe
    logic [SLV_WS-1:0] vld_q;
    logic [AXI_DW-1:0] dat_q [SLV_WS];
    logic              unused_vld;

    assign unused_vld = vld_q[SLV_WS-1];

    // Latency pipeline: a stage loads only behind a valid read, so the last
    // stage holds its value when no read completes; reset flushes everything.
    always_ff @(posedge usr_clk) begin
      if (usr_reset) begin
        vld_q <= '0;
        for (int s = 0; s < SLV_WS; s++) dat_q[s] <= '0;
      end else begin
        vld_q[0] <= m_re;
        if (m_re) dat_q[0] <= rd_mux;
        for (int s = 1; s < SLV_WS; s++) begin
          vld_q[s] <= vld_q[s-1];
          if (vld_q[s-1]) dat_q[s] <= dat_q[s-1];
        end
      end
    end

    assign m_rdata = dat_q[SLV_WS-1];
  end

  assign ctrl_o = ctrl_q;
  assign irq    = irq_q;

endmodule
`default_nettype wire

// File: tb/tb_asi_regbank.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : tb_asi_regbank
// Brief  : Directed bench for asi_regbank; three instances (SLV_WS 0/1/2)
//          share one stimulus stream. Expected values are hand-computed.
// Rev    : 1.0  initial release
// ============================================================================
module tb_asi_regbank;

  localparam int DW = 128;
  localparam int AW = 40;
  localparam int SW = 16;
  localparam int EW = 8;

  localparam logic [DW-1:0] ID_EXP = DW'(32'hA51_0001);
  localparam logic [DW-1:0] GP_PAT = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;

  localparam logic [AW-1:0] A_ID   = 40'h00;
  localparam logic [AW-1:0] A_SCR  = 40'h10;
  localparam logic [AW-1:0] A_CTRL = 40'h20;
  localparam logic [AW-1:0] A_CNT  = 40'h30;
  localparam logic [AW-1:0] A_STS  = 40'h40;
  localparam logic [AW-1:0] A_ERR  = 40'h50;
  localparam logic [AW-1:0] A_RSV  = 40'h60;
  localparam logic [AW-1:0] A_GP8  = 40'h80;
  localparam logic [AW-1:0] A_GP15 = 40'hF0;
  localparam logic [AW-1:0] A_BAD  = 40'h1010;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [SW-1:0] wstrb;
  logic          we, re;
  logic [EW-1:0] evt;
  logic [DW-1:0] rdata0, rdata1, rdata2;
  logic [31:0]   ctrl0, ctrl1, ctrl2;
  logic          irq0, irq1, irq2;

  int n_tests = 0;
  int n_fail  = 0;

  logic [DW-1:0] d0, d1, d2e, d2;
  logic [DW-1:0] scr_exp;

  asi_regbank #(.SLV_WS(0)) u_dut0 (
    .usr_clk(clk), .usr_reset(rst), .m_addr(addr), .m_wdata(wdata), .m_wstrb(wstrb),
    .m_we(we), .m_re(re), .m_rdata(rdata0), .evt(evt), .ctrl_o(ctrl0), .irq(irq0));

  asi_regbank #(.SLV_WS(1)) u_dut1 (
    .usr_clk(clk), .usr_reset(rst), .m_addr(addr), .m_wdata(wdata), .m_wstrb(wstrb),
    .m_we(we), .m_re(re), .m_rdata(rdata1), .evt(evt), .ctrl_o(ctrl1), .irq(irq1));

  asi_regbank #(.SLV_WS(2)) dut (
    .usr_clk(clk), .usr_reset(rst), .m_addr(addr), .m_wdata(wdata), .m_wstrb(wstrb),
    .m_we(we), .m_re(re), .m_rdata(rdata2), .evt(evt), .ctrl_o(ctrl2), .irq(irq2));

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called at a negedge; the write commits on the following posedge.
  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s);
    addr  = a;
    wdata = d;
    wstrb = s;
    we    = 1'b1;
    @(negedge clk);
    we    = 1'b0;
    wstrb = '0;
  endtask

  // Returns the SLV_WS=0 value (same cycle), SLV_WS=1 value (1 edge later),
  // SLV_WS=2 output after 1 edge (still old) and after 2 edges.
  task automatic rd(input logic [AW-1:0] a, output logic [DW-1:0] r0, output logic [DW-1:0] r1,
                    output logic [DW-1:0] r2e, output logic [DW-1:0] r2);
    addr = a;
    re   = 1'b1;
    #1 r0 = rdata0;
    @(negedge clk);
    re  = 1'b0;
    r1  = rdata1;
    r2e = rdata2;
    @(negedge clk);
    r2  = rdata2;
  endtask

  task automatic rdv(input logic [AW-1:0] a, output logic [DW-1:0] r2);
    logic [DW-1:0] x0, x1, x2e;
    rd(a, x0, x1, x2e, r2);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; addr = '0; wdata = '0; wstrb = '0; we = 1'b0; re = 1'b0; evt = '0;
    repeat (3) @(negedge clk);
    check("rst_rdata", rdata2, '0);
    check("rst_irq", DW'(irq2), '0);
    check("rst_ctrl", DW'(ctrl2), '0);
    rst = 1'b0;

    // ID read and latency per instance
    rd(A_ID, d0, d1, d2e, d2);
    check("id_ws0", d0, ID_EXP);
    check("id_ws1", d1, ID_EXP);
    check("id_ws2_early", d2e, '0);
    check("id_ws2", d2, ID_EXP);
    repeat (2) @(negedge clk);
    check("rdata_hold", rdata2, ID_EXP);

    // SCRATCH byte-strobe writes
    wr(A_SCR, DW'(32'hDEADBEEF), 16'h000F);
    rd(A_SCR, d0, d1, d2e, d2);
    check("scr_word_ws0", d0, DW'(32'hDEADBEEF));
    check("scr_word_ws1", d1, DW'(32'hDEADBEEF));
    check("scr_word", d2, DW'(32'hDEADBEEF));
    wr(A_SCR, DW'(8'h11), 16'h0001);
    rdv(A_SCR, d2);
    check("scr_byte", d2, DW'(32'hDEADBE11));
    wr(A_SCR, {DW{1'b1}}, 16'h8000);
    scr_exp = {8'hFF, 88'h0, 32'hDEADBE11};
    rdv(A_SCR, d2);
    check("scr_top_lane", d2, scr_exp);

    // RO and reserved writes are dropped; GP registers decode independently
    wr(A_RSV, {DW{1'b1}}, 16'hFFFF);
    rdv(A_RSV, d2);
    check("rsv_read0", d2, '0);
    wr(A_ID, {DW{1'b1}}, 16'hFFFF);
    rdv(A_ID, d2);
    check("id_ro", d2, ID_EXP);
    wr(A_GP15, GP_PAT, 16'hFFFF);
    rdv(A_GP15, d2);
    check("gp15_rw", d2, GP_PAT);
    rdv(A_GP8, d2);
    check("gp8_untouched", d2, '0);

    // Counter: enable, run 10 cycles, clear, resume
    wr(A_CTRL, DW'(32'h1), 16'h000F);
    repeat (10) @(negedge clk);
    rdv(A_CNT, d2);
    check("cnt_10", d2, DW'(64'd10));
    wr(A_CTRL, DW'(32'h3), 16'h000F);
    rdv(A_CNT, d2);
    check("cnt_clr", d2, '0);
    rdv(A_CNT, d2);
    check("cnt_resume", d2, DW'(64'd2));
    rdv(A_CTRL, d2);
    check("ctrl_clr_reads0", d2, DW'(32'h1));
    check("ctrl_o", DW'(ctrl2), DW'(32'h1));

    // Counter wrap from a preloaded value, one increment per enable pulse
    wr(A_CTRL, '0, 16'h000F);
    force dut.cnt_q = 64'hFFFF_FFFF_FFFF_FFFE;
    @(negedge clk);
    release dut.cnt_q;
    rdv(A_CNT, d2);
    check("cnt_preload", d2, DW'(64'hFFFF_FFFF_FFFF_FFFE));
    wr(A_CTRL, DW'(32'h1), 16'h000F);
    wr(A_CTRL, '0, 16'h000F);
    rdv(A_CNT, d2);
    check("cnt_max", d2, DW'(64'hFFFF_FFFF_FFFF_FFFF));
    wr(A_CTRL, DW'(32'h1), 16'h000F);
    wr(A_CTRL, '0, 16'h000F);
    rdv(A_CNT, d2);
    check("cnt_wrap", d2, '0);

    // STATUS / irq
    wr(A_CTRL, DW'(32'h0000_0800), 16'h000F);
    check("ctrl_mask", DW'(ctrl2), DW'(32'h0000_0800));
    check("ctrl_mask_ws1", DW'(ctrl1), DW'(32'h0000_0800));
    evt = 8'h08;
    @(negedge clk);
    evt = '0;
    check("irq_not_yet", DW'(irq2), '0);
    @(negedge clk);
    check("irq_set", DW'(irq2), DW'(1'b1));
    rdv(A_STS, d2);
    check("sts_set", d2, DW'(8'h08));
    wr(A_STS, DW'(8'h08), 16'h0002);
    rdv(A_STS, d2);
    check("sts_wrong_lane", d2, DW'(8'h08));
    addr = A_STS; wdata = DW'(8'h08); wstrb = 16'h0001; we = 1'b1; evt = 8'h08;
    @(negedge clk);
    we = 1'b0; wstrb = '0; evt = '0;
    rdv(A_STS, d2);
    check("sts_set_wins", d2, DW'(8'h08));
    wr(A_STS, DW'(8'h08), 16'h0001);
    rdv(A_STS, d2);
    check("sts_cleared", d2, '0);
    check("irq_cleared", DW'(irq2), '0);
    evt = 8'h20;
    @(negedge clk);
    evt = '0;
    repeat (2) @(negedge clk);
    check("irq_masked", DW'(irq2), '0);
    rdv(A_STS, d2);
    check("sts_bit5", d2, DW'(8'h20));
    wr(A_STS, DW'(8'h20), 16'h0001);

    // Unmapped accesses
    rdv(A_ID, d2);
    rdv(A_BAD, d2);
    check("unmapped_rd0", d2, '0);
    rdv(A_ERR, d2);
    check("errcnt_1", d2, DW'(16'd1));
    addr = A_BAD; wdata = {DW{1'b1}}; wstrb = 16'hFFFF; we = 1'b1; re = 1'b1;
    @(negedge clk);
    we = 1'b0; re = 1'b0; wstrb = '0;
    rdv(A_ERR, d2);
    check("errcnt_we_re_once", d2, DW'(16'd2));
    rdv(A_SCR, d2);
    check("unmapped_wr_dropped", d2, scr_exp);
    addr = A_BAD;
    re   = 1'b1;
    repeat (65536) @(negedge clk);
    re = 1'b0;
    rdv(A_ERR, d2);
    check("errcnt_sat", d2, DW'(16'hFFFF));
    rdv(A_BAD, d2);
    rdv(A_ERR, d2);
    check("errcnt_held", d2, DW'(16'hFFFF));

    // Back-to-back reads, one result per cycle
    addr = A_ID; re = 1'b1;
    @(negedge clk);
    addr = A_GP15;
    @(negedge clk);
    check("b2b_0", rdata2, ID_EXP);
    addr = A_SCR;
    @(negedge clk);
    check("b2b_1", rdata2, GP_PAT);
    re = 1'b0;
    @(negedge clk);
    check("b2b_2", rdata2, scr_exp);

    // Reset in the middle of a read burst flushes in-flight data
    addr = A_GP15; re = 1'b1;
    @(negedge clk);
    addr = A_ID;
    @(negedge clk);
    check("pre_rst_data", rdata2, GP_PAT);
    re = 1'b0; rst = 1'b1;
    @(negedge clk);
    check("flush_a", rdata2, '0);
    rst = 1'b0;
    @(negedge clk);
    check("flush_b", rdata2, '0);
    @(negedge clk);
    check("flush_c", rdata2, '0);
    check("flush_ws1", rdata1, '0);
    rdv(A_SCR, d2);
    check("scr_after_rst", d2, '0);
    rd(A_ID, d0, d1, d2e, d2);
    check("id_after_rst_ws0", d0, ID_EXP);
    check("id_after_rst_ws1", d1, ID_EXP);
    check("id_after_rst_ws2", d2, ID_EXP);
    check("irq_after_rst", DW'({irq0, irq1, irq2}), '0);
    check("ctrl_after_rst", DW'(ctrl0 | ctrl1 | ctrl2), '0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
